regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-side front end for the 32x32-bit register file (two read ports, one write port, register 0 hardwired to zero).
- Accepts writeback requests from execution units over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drains one entry per cycle onto the register file write port.
- Forwards pending (not-yet-written) data onto both read paths, so readers never see stale register contents.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in_valid  input  1  writeback request valid.
- in_ready  output  1  queue can accept a request this cycle.
- in_rd  input  5  destination register index.
- in_data  input  32  writeback data.
- hold  input  1  when high, suppress draining (queue still accepts).
- rf_we  output  1  register file write enable.
- rf_waddr  output  5  register file write index.
- rf_wdata  output  32  register file write data.
- rd_addr_a  input  5  read port A index (same index driven to the register file).
- rd_addr_b  input  5  read port B index.
- rf_rdata_a  input  32  raw register file read data, port A.
- rf_rdata_b  input  32  raw register file read data, port B.
- fwd_data_a  output  32  forwarded read data, port A.
- fwd_data_b  output  32  forwarded read data, port B.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (clr high, async):
  - Read and write pointers, count and all entry valid bits go to 0.
  - Resulting outputs: rf_we=0, empty=1, count=0, in_ready=1.
  - Asserting clr mid-operation discards all pending entries; none of them is written to the register file.
- Enqueue:
  - A handshake occurs on a rising edge with in_valid && in_ready.
  - in_ready = (count != DEPTH), combinational from state only; it does not depend on in_valid or on a same-cycle dequeue.
  - Requests with in_rd == 0 complete the handshake but are discarded: no entry is written and count is unchanged.
- Dequeue:
  - rf_we = !empty && !hold. rf_waddr and rf_wdata come combinationally from the head entry.
  - On a rising edge with rf_we=1, the head is popped and the register file captures it on the same edge.
  - Latency: a request accepted at edge N appears on rf_we during cycle N+1 at the earliest (queue empty, hold low). It is written at edge N+1.
- Simultaneous enqueue and dequeue on one edge:
  - Count is unchanged and both pointers advance.
  - When count==DEPTH no enqueue occurs (in_ready=0), even if a dequeue happens on the same edge.
- Pointer and count arithmetic:
  - Pointers are AW bits and wrap modulo DEPTH.
  - count is AW+1 bits and never exceeds DEPTH or drops below 0.
- Forwarding (combinational, per port X in {a,b}):
  - If rd_addr_X == 0, fwd_data_X = 0.
  - Else, if any valid entry (including the head currently driven on rf_we) has rd == rd_addr_X, fwd_data_X is that entry's data. If several entries match, the youngest (most recently enqueued) wins.
  - Else fwd_data_X = rf_rdata_X.
  - The request currently presented on in_* is not forwarded until after it is enqueued.
- hold:
  - hold high freezes draining only.
  - The queue may fill; in_ready then drops to 0 and stays 0 until hold falls and a pop occurs.
- Duplicates: multiple entries for the same rd are legal. They are written in FIFO order, so the last write wins in the register file, consistent with forwarding.

Test Plan:
- Reset, then one request rd=5, data=0xDEADBEEF with hold=0 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF for exactly one cycle after acceptance; count goes 1 then 0.
- hold=1; enqueue rd=1..4 with data=0x11..0x44 -> count=4, in_ready=0, fifth request stalls. Release hold -> writes rd=1,2,3,4 in order on four consecutive cycles, and in_ready=1 after the first pop.
- hold=1; enqueue rd=7 data=0xA, then rd=7 data=0xB; rd_addr_a=7, rf_rdata_a=0x0 -> fwd_data_a=0xB. Drain one entry -> fwd_data_a still 0xB. Drain the second -> fwd_data_a tracks rf_rdata_a.
- Enqueue rd=0 data=0xFFFFFFFF -> handshake completes, count stays 0, rf_we never asserts. With rd_addr_b=0 and rf_rdata_b=0x1234, fwd_data_b=0.
- Queue at count=4 with hold=0 while in_valid is held high continuously -> no enqueue on the full cycle. Subsequent cycles show a simultaneous push and pop with count steady at 3 or 4, and pointers wrap past DEPTH-1 with data order preserved across the wrap.
- Three entries pending, assert clr asynchronously mid-cycle -> rf_we drops immediately, count=0, empty=1. No pending entry is ever written, and fwd outputs revert to rf_rdata.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue
//
// Purpose:
//   Write-side front end for the 32x32 register file. Writeback requests from
//   the execution units are buffered in a DEPTH-entry FIFO. The FIFO drains
//   one entry per cycle onto the register file write port. Data that is still
//   pending is forwarded onto both read paths, so readers never observe a
//   stale register value.
//
// Ports:
//   clk, clr            clock; asynchronous active-high reset
//   in_valid/in_ready   writeback request handshake
//   in_rd, in_data      destination register index and data
//   hold                suppresses draining; the queue still accepts requests
//   rf_we/waddr/wdata   register file write port, driven from the head entry
//   rd_addr_a/b         read indices, also driven to the register file
//   rf_rdata_a/b        raw register file read data
//   fwd_data_a/b        read data with pending writes forwarded
//   count, empty        occupancy
// ---------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rd,
    input  logic [31:0]   in_data,
    input  logic          hold,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    input  logic [4:0]    rd_addr_a,
    input  logic [4:0]    rd_addr_b,
    input  logic [31:0]   rf_rdata_a,
    input  logic [31:0]   rf_rdata_b,
    output logic [31:0]   fwd_data_a,
    output logic [31:0]   fwd_data_b,
    output logic [AW:0]   count,
    output logic          empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Entry storage. Payload needs no reset: only entries whose valid bit is
    // set are ever observed.
    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid_next;
    logic [AW:0]      w_count_next;

    assign empty    = (r_count == '0);
    assign count    = r_count;
    // Depends on state only; a same-cycle pop does not open a slot.
    assign in_ready = (r_count != FULL_COUNT);

    assign rf_we    = !empty && !hold;
    assign rf_waddr = r_rd[r_rptr];
    assign rf_wdata = r_data[r_rptr];

    // Writes to register 0 complete the handshake but are dropped here.
    assign w_push = in_valid && in_ready && (in_rd != 5'd0);
    assign w_pop  = rf_we;

    // Push and pop never hit the same slot on one edge: they could only
    // coincide when the queue is empty (no pop) or full (no push).
    always_comb begin
        w_valid_next = r_valid;
        if (w_pop) begin
            w_valid_next[r_rptr] = 1'b0;
        end
        if (w_push) begin
            w_valid_next[r_wptr] = 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
            r_valid <= w_valid_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wptr == AW'(gi))) begin
                    r_rd[gi]   <= in_rd;
                    r_data[gi] <= in_data;
                end
            end
        end
    endgenerate

    // Walk the occupied entries from oldest (read pointer) to youngest, so a
    // later match overrides an earlier one and the youngest write wins.
    function automatic logic [31:0] fwd_lookup(input logic [4:0]  addr,
                                               input logic [31:0] raw);
        logic [31:0]   res;
        logic [AW-1:0] idx;
        res = raw;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_rptr + AW'(k);
            if (r_valid[idx] && (r_rd[idx] == addr)) begin
                res = r_data[idx];
            end
        end
        if (addr == 5'd0) begin
            res = 32'd0;
        end
        return res;
    endfunction

    assign fwd_data_a = fwd_lookup(rd_addr_a, rf_rdata_a);
    assign fwd_data_b = fwd_lookup(rd_addr_b, rf_rdata_b);

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue
//
// Self-checking bench for regfile_wb_queue: a directed vector table, a few
// hand-written multi-cycle sequences (fill under hold, full queue with
// continuous requests and pointer wrap, asynchronous clear) and a randomized
// run, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rd;
    logic [31:0]   in_data;
    logic          hold;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [4:0]    rd_addr_a;
    logic [4:0]    rd_addr_b;
    logic [31:0]   rf_rdata_a;
    logic [31:0]   rf_rdata_b;
    logic [31:0]   fwd_data_a;
    logic [31:0]   fwd_data_b;
    logic [AW:0]   count;
    logic          empty;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .hold       (hold),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the pending writes, oldest first.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] addr, input logic [31:0] raw);
        logic [31:0] res;
        res = raw;
        if (addr == 5'd0) return 32'd0;
        foreach (mq[i]) begin
            if (mq[i].rd == addr) res = mq[i].d;
        end
        return res;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check outputs
    // against the model, then advance the model across the rising edge.
    task automatic step(input logic iv, input logic [4:0] rd, input logic [31:0] d,
                        input logic h, input logic [4:0] ra, input logic [31:0] rda,
                        input logic [4:0] rb, input logic [31:0] rdb);
        int   exp_cnt;
        logic exp_ready;
        logic exp_we;
        ent_t e;
        @(negedge clk);
        in_valid = iv; in_rd = rd; in_data = d; hold = h;
        rd_addr_a = ra; rf_rdata_a = rda; rd_addr_b = rb; rf_rdata_b = rdb;
        #1;
        exp_cnt   = mq.size();
        exp_ready = (exp_cnt != DEPTH);
        exp_we    = (exp_cnt != 0) && !h;
        chk("count",    32'(count), 32'(exp_cnt));
        chk("empty",    32'(empty), 32'(exp_cnt == 0));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("rf_we",    32'(rf_we), 32'(exp_we));
        if (exp_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(mq[0].rd));
            chk("rf_wdata", rf_wdata, mq[0].d);
        end
        chk("fwd_data_a", fwd_data_a, model_fwd(ra, rda));
        chk("fwd_data_b", fwd_data_b, model_fwd(rb, rdb));
        @(posedge clk);
        if (exp_we) begin
            $display("write rd=%0d data=0x%08h", mq[0].rd, mq[0].d);
            void'(mq.pop_front());
        end
        if (iv && exp_ready && rd != 5'd0) begin
            e.rd = rd; e.d = d;
            mq.push_back(e);
        end
    endtask

    // Directed vectors; expectations describe the state before each edge.
    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        h;
        logic [4:0]  ra;
        logic [31:0] rda;
        int          e_cnt;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_fwd;
    } vec_t;

    vec_t vt[11];

    initial begin
        clr = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; hold = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; rf_rdata_a = '0; rf_rdata_b = '0;

        //            iv  rd  data          h  ra  rda           cnt rdy we waddr wdata         fwd
        vt[0]  = '{1'b1, 5, 32'hDEADBEEF, 0, 5, 32'h00000055, 0, 1, 0, 0, 32'h0,        32'h00000055};
        vt[1]  = '{1'b0, 0, 32'h0,        0, 5, 32'h00000055, 1, 1, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 0, 32'h0,        0, 5, 32'h00000055, 0, 1, 0, 0, 32'h0,        32'h00000055};
        vt[3]  = '{1'b1, 7, 32'h0000000A, 1, 7, 32'h00000000, 0, 1, 0, 0, 32'h0,        32'h00000000};
        vt[4]  = '{1'b1, 7, 32'h0000000B, 1, 7, 32'h00000000, 1, 1, 0, 0, 32'h0,        32'h0000000A};
        vt[5]  = '{1'b0, 0, 32'h0,        1, 7, 32'h00000000, 2, 1, 0, 0, 32'h0,        32'h0000000B};
        vt[6]  = '{1'b0, 0, 32'h0,        0, 7, 32'h00000000, 2, 1, 1, 7, 32'h0000000A, 32'h0000000B};
        vt[7]  = '{1'b0, 0, 32'h0,        0, 7, 32'h00000000, 1, 1, 1, 7, 32'h0000000B, 32'h0000000B};
        vt[8]  = '{1'b0, 0, 32'h0,        0, 7, 32'h00000077, 0, 1, 0, 0, 32'h0,        32'h00000077};
        vt[9]  = '{1'b1, 0, 32'hFFFFFFFF, 0, 0, 32'h00001234, 0, 1, 0, 0, 32'h0,        32'h00000000};
        vt[10] = '{1'b0, 0, 32'h0,        0, 0, 32'h00001234, 0, 1, 0, 0, 32'h0,        32'h00000000};

        // Reset state while clr is held.
        #12;
        chk("reset count",    32'(count), 32'd0);
        chk("reset empty",    32'(empty), 32'd1);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset rf_we",    32'(rf_we), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = vt[i].iv; in_rd = vt[i].rd; in_data = vt[i].d; hold = vt[i].h;
            rd_addr_a = vt[i].ra; rf_rdata_a = vt[i].rda;
            rd_addr_b = vt[i].ra; rf_rdata_b = vt[i].rda;
            #1;
            $display("vec %0d: valid=%0d rd=%0d hold=%0d count=%0d we=%0d waddr=%0d fwd_a=0x%08h",
                     i, vt[i].iv, vt[i].rd, vt[i].h, count, rf_we, rf_waddr, fwd_data_a);
            chk("vec count",    32'(count), 32'(vt[i].e_cnt));
            chk("vec in_ready", 32'(in_ready), 32'(vt[i].e_ready));
            chk("vec rf_we",    32'(rf_we), 32'(vt[i].e_we));
            if (vt[i].e_we) begin
                chk("vec rf_waddr", 32'(rf_waddr), 32'(vt[i].e_waddr));
                chk("vec rf_wdata", rf_wdata, vt[i].e_wdata);
            end
            chk("vec fwd_data_a", fwd_data_a, vt[i].e_fwd);
            chk("vec fwd_data_b", fwd_data_b, vt[i].e_fwd);
            @(posedge clk);
        end

        // Fill under hold, stall a fifth request, then drain in order.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'(i), 32'(i * 32'h11), 1'b1, 5'(i), 32'h0, 5'd3, 32'h33330000);
        step(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 32'hAAAA, 5'd4, 32'h0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 32'hC0DE, 5'd4, 32'hF00D);

        // Full queue, hold released, requests continuously valid: the pointers
        // wrap several times and data order must be kept.
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'(8 + i), 32'h200 + 32'(i), 1'b1, 5'd9, 32'h0, 5'd12, 32'h0);
        for (int i = 0; i < 12; i++)
            step(1'b1, 5'(16 + (i % 5)), 32'h300 + 32'(i), 1'b0, 5'(16 + (i % 5)), 32'h1,
                 5'(17 + (i % 3)), 32'h2);
        for (int i = 0; i < 5; i++)
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd18, 32'hBEEF, 5'd19, 32'hCAFE);

        // Three pending entries, then an asynchronous clear mid-cycle.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(9 + i), 32'h900 + 32'(i), 1'b1, 5'd9, 32'h0, 5'd10, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; hold = 1'b0;
        rd_addr_a = 5'd9;  rf_rdata_a = 32'h99;
        rd_addr_b = 5'd11; rf_rdata_b = 32'hBB;
        #1;
        chk("pre-clr rf_we",  32'(rf_we), 32'd1);
        chk("pre-clr fwd_a",  fwd_data_a, 32'h900);
        #2;
        clr = 1'b1;
        #1;
        $display("async clear: count=%0d we=%0d", count, rf_we);
        chk("clr rf_we",    32'(rf_we), 32'd0);
        chk("clr count",    32'(count), 32'd0);
        chk("clr empty",    32'(empty), 32'd1);
        chk("clr in_ready", 32'(in_ready), 32'd1);
        chk("clr fwd_a",    fwd_data_a, 32'h99);
        chk("clr fwd_b",    fwd_data_b, 32'hBB);
        @(posedge clk);
        #1;
        chk("clr held rf_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        mq.delete();
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'(9 + i), 32'h5A5A, 5'd10, 32'hA5A5);

        // Randomized traffic with a small register range to force duplicates.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)),
                 $urandom(),
                 ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
